// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between IF (read-only) and LSU (read/write), one transaction in flight.
// Latency: request to grant 1 cycle, grant to rvalid 2 cycles minimum; backpressure via mem_ready; optional ARB_ROUND_ROBIN_EN.
module mem_port_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int MAX_LSU_STREAK = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [31:0]       if_rdata,
    input  logic              lsu_req,
    input  logic              lsu_we,
    input  logic [ADDR_W-1:0] lsu_addr,
    input  logic [31:0]       lsu_wdata,
    input  logic [3:0]        lsu_be,
    output logic              lsu_gnt,
    output logic              lsu_rvalid,
    output logic [31:0]       lsu_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_be,
    input  logic              mem_ready,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata,
    output logic              busy,
    output logic              err_spurious
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic       OWN_IF  = 1'b0;
    localparam logic       OWN_LSU = 1'b1;

    logic [1:0]        state_q, state_d;
    logic              owner_q, owner_d;
    logic              if_gnt_q, if_gnt_d, lsu_gnt_q, lsu_gnt_d;
    logic              if_rvalid_q, if_rvalid_d, lsu_rvalid_q, lsu_rvalid_d;
    logic [31:0]       if_rdata_q, if_rdata_d, lsu_rdata_q, lsu_rdata_d;
    logic              mem_req_q, mem_req_d, mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic [3:0]        mem_be_q, mem_be_d;
    logic              busy_q, busy_d, err_q, err_d;
    logic              pick_lsu;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_q, last_d;
    // On contention the side that lost the previous grant goes next.
    assign pick_lsu = lsu_req && (!if_req || (last_q == OWN_IF));
`else
    localparam logic [3:0] STREAK_MAX = 4'(MAX_LSU_STREAK);
    logic [3:0] streak_q, streak_d;
    assign pick_lsu = lsu_req && (!if_req || (streak_q != STREAK_MAX));
`endif

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        if_gnt_d     = 1'b0;
        lsu_gnt_d    = 1'b0;
        if_rvalid_d  = 1'b0;
        lsu_rvalid_d = 1'b0;
        if_rdata_d   = 32'h0;
        lsu_rdata_d  = 32'h0;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_be_d     = mem_be_q;
        err_d        = err_q | (mem_rvalid && (state_q != S_WAIT));
`ifdef ARB_ROUND_ROBIN_EN
        last_d       = last_q;
`else
        streak_d     = streak_q;
`endif
        case (state_q)
            S_IDLE: begin
`ifndef ARB_ROUND_ROBIN_EN
                if (!if_req) streak_d = 4'd0;
`endif
                if (if_req || lsu_req) begin
                    state_d   = S_ISSUE;
                    mem_req_d = 1'b1;
                    owner_d   = pick_lsu ? OWN_LSU : OWN_IF;
                    if (pick_lsu) begin
                        lsu_gnt_d   = 1'b1;
                        mem_we_d    = lsu_we;
                        mem_addr_d  = lsu_addr;
                        mem_wdata_d = lsu_wdata;
                        mem_be_d    = lsu_be;
                    end else begin
                        if_gnt_d    = 1'b1;
                        mem_we_d    = 1'b0;
                        mem_addr_d  = if_addr;
                        mem_wdata_d = 32'h0;
                        mem_be_d    = 4'hF;
                    end
`ifdef ARB_ROUND_ROBIN_EN
                    last_d = pick_lsu ? OWN_LSU : OWN_IF;
`else
                    if (!pick_lsu)
                        streak_d = 4'd0;
                    else if (if_req && (streak_q != STREAK_MAX))
                        streak_d = streak_q + 4'd1;
`endif
                end
            end
            S_ISSUE: begin
                if (mem_ready) begin
                    mem_req_d = 1'b0;
                    state_d   = S_WAIT;
                end
            end
            S_WAIT: begin
                if (mem_rvalid) begin
                    state_d = S_IDLE;
                    if (owner_q == OWN_LSU) begin
                        lsu_rvalid_d = 1'b1;
                        lsu_rdata_d  = mem_we_q ? 32'h0 : mem_rdata;
                    end else begin
                        if_rvalid_d = 1'b1;
                        if_rdata_d  = mem_rdata;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            owner_q      <= OWN_IF;
            if_gnt_q     <= 1'b0;
            lsu_gnt_q    <= 1'b0;
            if_rvalid_q  <= 1'b0;
            lsu_rvalid_q <= 1'b0;
            if_rdata_q   <= 32'h0;
            lsu_rdata_q  <= 32'h0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= 32'h0;
            mem_be_q     <= 4'h0;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            last_q       <= OWN_IF;
`else
            streak_q     <= 4'd0;
`endif
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            if_gnt_q     <= if_gnt_d;
            lsu_gnt_q    <= lsu_gnt_d;
            if_rvalid_q  <= if_rvalid_d;
            lsu_rvalid_q <= lsu_rvalid_d;
            if_rdata_q   <= if_rdata_d;
            lsu_rdata_q  <= lsu_rdata_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_be_q     <= mem_be_d;
            busy_q       <= busy_d;
            err_q        <= err_d;
`ifdef ARB_ROUND_ROBIN_EN
            last_q       <= last_d;
`else
            streak_q     <= streak_d;
`endif
        end
    end

    assign if_gnt       = if_gnt_q;
    assign lsu_gnt      = lsu_gnt_q;
    assign if_rvalid    = if_rvalid_q;
    assign lsu_rvalid   = lsu_rvalid_q;
    assign if_rdata     = if_rdata_q;
    assign lsu_rdata    = lsu_rdata_q;
    assign mem_req      = mem_req_q;
    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign mem_be       = mem_be_q;
    assign busy         = busy_q;
    assign err_spurious = err_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-level model of requesters, memory and arbitration policy.
module tb_mem_port_arbiter;
    localparam int AW   = 32;
    localparam int MAXS = 4;

    logic          clk = 1'b0;
    logic          rst, if_req, lsu_req, lsu_we, mem_ready, mem_rvalid;
    logic [AW-1:0] if_addr, lsu_addr;
    logic [31:0]   lsu_wdata, mem_rdata;
    logic [3:0]    lsu_be;
    logic          if_gnt, if_rvalid, lsu_gnt, lsu_rvalid, mem_req, mem_we, busy, err_spurious;
    logic [31:0]   if_rdata, lsu_rdata, mem_wdata;
    logic [AW-1:0] mem_addr;
    logic [3:0]    mem_be;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(AW), .MAX_LSU_STREAK(MAXS)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata), .lsu_be(lsu_be),
        .lsu_gnt(lsu_gnt), .lsu_rvalid(lsu_rvalid), .lsu_rdata(lsu_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .busy(busy), .err_spurious(err_spurious)
    );

    int n_cmp = 0, n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Requesters
    int          if_mode = 0, lsu_mode = 0;
    bit          if_pend = 0, lsu_pend = 0, prev_if = 0, prev_lsu = 0, rst_drv = 1, rst_next = 1;
    logic [31:0] if_a, lsu_a, lsu_d;
    logic        lsu_w;
    logic [3:0]  lsu_b;
    // Model of the transaction in flight and the arbitration history
    bit          txn_open = 0, accepted = 0, own_lsu = 0, last_lsu_m = 0, err_exp = 0;
    int          streak_m = 0;
    logic [31:0] e_addr, e_wdata;
    logic        e_we;
    logic [3:0]  e_be;
    // Memory environment
    logic [31:0] mem_arr [16];
    bit          resp_active = 0, resp_to_dut = 0, spur_now = 0;
    int          resp_cnt = 0, ready_prob = 100, ready_wait = 0, min_delay = 0, max_delay = 0;
    logic [31:0] resp_exp, resp_drv;
    // Observations for directed checks
    int          cyc = 0, if_req_cyc = 0, gnt_cyc = 0, rv_cyc = 0, memreq_cnt = 0, if_rv_cnt = 0, lsu_rv_cnt = 0;
    logic [31:0] last_if_rdata, last_lsu_rdata, g_addr;
    logic [4:0]  g_webe;
    bit          gnt_log [$];

    task automatic step();
        bit         g_any, w_lsu;
        logic [3:0] idx;
        @(negedge clk);
        cyc++;
        if (rst_drv) begin
            chk("rst_ctrl", {if_gnt, if_rvalid, lsu_gnt, lsu_rvalid, mem_req, mem_we, mem_be, busy, err_spurious}, 0);
            chk("rst_data", {if_rdata, lsu_rdata}, 0);
            chk("rst_mem", {mem_addr, mem_wdata}, 0);
            txn_open = 0; accepted = 0; streak_m = 0; last_lsu_m = 0; err_exp = 0; resp_to_dut = 0;
        end else begin
            g_any = !txn_open && (prev_if || prev_lsu);
`ifdef ARB_ROUND_ROBIN_EN
            w_lsu = prev_lsu && (!prev_if || !last_lsu_m);
`else
            // LSU may jump a waiting IF request only MAXS times in a row.
            w_lsu = prev_lsu && (!prev_if || streak_m < MAXS);
`endif
            chk("if_gnt", if_gnt, g_any && !w_lsu);
            chk("lsu_gnt", lsu_gnt, g_any && w_lsu);
            if (g_any) begin
`ifdef ARB_ROUND_ROBIN_EN
                last_lsu_m = w_lsu;
`else
                streak_m = (w_lsu && prev_if) ? streak_m + 1 : 0;
`endif
                txn_open = 1; accepted = 0; own_lsu = w_lsu; memreq_cnt = 0; gnt_cyc = cyc;
                gnt_log.push_back(w_lsu);
                g_addr = mem_addr; g_webe = {mem_we, mem_be};
                if (w_lsu) begin
                    e_addr = lsu_a; e_we = lsu_w; e_wdata = lsu_d; e_be = lsu_b; lsu_pend = 0;
                end else begin
                    e_addr = if_a; e_we = 1'b0; e_wdata = 32'h0; e_be = 4'hF; if_pend = 0;
                end
            end
            chk("if_rvalid", if_rvalid, resp_to_dut && !own_lsu);
            chk("lsu_rvalid", lsu_rvalid, resp_to_dut && own_lsu);
            if (resp_to_dut) begin
                chk("owner_rdata", own_lsu ? lsu_rdata : if_rdata, resp_exp);
                chk("other_rdata", own_lsu ? if_rdata : lsu_rdata, 0);
                if (own_lsu) begin lsu_rv_cnt++; last_lsu_rdata = lsu_rdata; end
                else begin if_rv_cnt++; last_if_rdata = if_rdata; end
                rv_cyc = cyc; txn_open = 0;
            end
            resp_to_dut = 0;
            chk("mem_req", mem_req, txn_open && !accepted);
            if (txn_open && !accepted) begin
                memreq_cnt++;
                chk("mem_addr", mem_addr, e_addr);
                chk("mem_we_be_wdata", {mem_we, mem_be, mem_wdata}, {e_we, e_be, e_wdata});
            end
            chk("busy", busy, txn_open);
            chk("err_spurious", err_spurious, err_exp);
        end

        rst_drv = rst_next;
        rst = rst_next;
        mem_rvalid = 1'b0;
        mem_rdata = $urandom;
        if (resp_active) begin
            if (resp_cnt == 0) begin mem_rvalid = 1'b1; mem_rdata = resp_drv; resp_active = 0; end
            else resp_cnt--;
        end
        if (spur_now) begin mem_rvalid = 1'b1; spur_now = 0; end
        if (mem_rvalid && !rst_next) begin
            if (txn_open && accepted) resp_to_dut = 1;
            else err_exp = 1;
        end
        mem_ready = 1'b0;
        if (txn_open && !accepted) begin
            if (ready_wait > 0) ready_wait--;
            else mem_ready = ($urandom_range(99) < ready_prob);
            if (mem_ready && !rst_next) begin
                accepted = 1;
                idx = e_addr[5:2];
                resp_exp = e_we ? 32'h0 : mem_arr[idx];
                resp_drv = e_we ? $urandom : mem_arr[idx];
                for (int b = 0; b < 4; b++)
                    if (e_we && e_be[b]) mem_arr[idx][8*b +: 8] = e_wdata[8*b +: 8];
                resp_active = 1;
                resp_cnt = $urandom_range(max_delay, min_delay);
            end
        end else begin
            mem_ready = ($urandom_range(3) == 0);
        end

        if (!if_pend && (if_mode == 2 || (if_mode == 1 && $urandom_range(2) == 0))) begin
            if_pend = 1; if_a = 32'($urandom_range(15)) << 2;
        end
        if (!lsu_pend && (lsu_mode == 2 || (lsu_mode == 1 && $urandom_range(2) == 0))) begin
            lsu_pend = 1; lsu_a = 32'($urandom_range(15)) << 2; lsu_w = 1'($urandom_range(1));
            lsu_d = $urandom; lsu_b = 4'($urandom_range(15));
        end
        if (if_pend && !prev_if) if_req_cyc = cyc;
        if_req    = if_pend;
        if_addr   = if_pend ? if_a : $urandom;
        lsu_req   = lsu_pend;
        lsu_we    = lsu_pend ? lsu_w : 1'($urandom_range(1));
        lsu_addr  = lsu_pend ? lsu_a : $urandom;
        lsu_wdata = lsu_pend ? lsu_d : $urandom;
        lsu_be    = lsu_pend ? lsu_b : 4'($urandom_range(15));
        prev_if   = if_pend;
        prev_lsu  = lsu_pend;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200 && (txn_open || if_pend || lsu_pend || resp_active); i++) step();
        chk("idle_reached", (txn_open || if_pend || lsu_pend || resp_active) ? 0 : 1, 1);
    endtask

    task automatic pulse_reset();
        rst_next = 1; step(); step(); rst_next = 0; step();
    endtask

    initial begin
        int base_if, base_lsu;
        bit exp_order [6];
        rst = 1'b1; if_req = 0; lsu_req = 0; lsu_we = 0; mem_ready = 0; mem_rvalid = 0;
        if_addr = '0; lsu_addr = '0; lsu_wdata = '0; lsu_be = '0; mem_rdata = '0;
        for (int i = 0; i < 16; i++) mem_arr[i] = $urandom;
        mem_arr[4] = 32'h0040_0093;
        rst_next = 1; repeat (3) step(); rst_next = 0; step();

        // Single fetch, zero-wait memory
        base_lsu = lsu_rv_cnt; base_if = if_rv_cnt;
        if_a = 32'h0000_0010; if_pend = 1;
        for (int i = 0; i < 20 && if_rv_cnt == base_if; i++) step();
        chk("if_gnt_latency", gnt_cyc - if_req_cyc, 1);
        chk("if_rvalid_latency", rv_cyc - if_req_cyc, 3);
        chk("if_rdata_value", last_if_rdata, 32'h0040_0093);
        chk("if_mem_addr", g_addr, 32'h10);
        chk("if_mem_we_be", g_webe, 5'h0F);
        chk("if_no_lsu_rvalid", lsu_rv_cnt - base_lsu, 0);
        wait_idle();

        // Store held off by three cycles of backpressure
        base_lsu = lsu_rv_cnt;
        lsu_a = 32'h100; lsu_w = 1; lsu_d = 32'hDEAD_BEEF; lsu_b = 4'b0011; lsu_pend = 1; ready_wait = 3;
        for (int i = 0; i < 30 && lsu_rv_cnt == base_lsu; i++) step();
        repeat (3) step();
        chk("st_memreq_cycles", memreq_cnt, 4);
        chk("st_rvalid_count", lsu_rv_cnt - base_lsu, 1);
        chk("st_rdata_zero", last_lsu_rdata, 0);
        wait_idle();

        // Both requesters held continuously
        pulse_reset();
        gnt_log.delete();
        if_mode = 2; lsu_mode = 2;
        for (int i = 0; i < 100 && gnt_log.size() < 6; i++) step();
        if_mode = 0; lsu_mode = 0;
`ifdef ARB_ROUND_ROBIN_EN
        exp_order = '{1, 0, 1, 0, 1, 0};
`else
        exp_order = '{1, 1, 1, 1, 0, 1};
`endif
        chk("contest_count", gnt_log.size() >= 6, 1);
        for (int i = 0; i < 6; i++)
            chk($sformatf("contest_grant%0d_is_lsu", i), (i < gnt_log.size()) ? gnt_log[i] : 1'bx, exp_order[i]);
        wait_idle();

        // Random traffic with random backpressure and response delay
        base_if = if_rv_cnt; base_lsu = lsu_rv_cnt;
        ready_prob = 60; min_delay = 0; max_delay = 3; if_mode = 1; lsu_mode = 1;
        repeat (3000) step();
        if_mode = 0; lsu_mode = 0;
        wait_idle();
        chk("rand_if_served", (if_rv_cnt - base_if) > 50, 1);
        chk("rand_lsu_served", (lsu_rv_cnt - base_lsu) > 50, 1);

        // Response with nothing outstanding
        ready_prob = 100; max_delay = 0;
        base_if = if_rv_cnt; base_lsu = lsu_rv_cnt;
        spur_now = 1;
        repeat (6) step();
        chk("spur_sticky", err_spurious, 1);
        chk("spur_no_rvalid", (if_rv_cnt - base_if) + (lsu_rv_cnt - base_lsu), 0);

        // Reset while waiting for the response; the stale response lands afterwards
        pulse_reset();
        chk("err_cleared_by_rst", err_spurious, 0);
        min_delay = 6; max_delay = 6;
        base_if = if_rv_cnt;
        if_a = 32'h20; if_pend = 1;
        for (int i = 0; i < 20 && !accepted; i++) step();
        rst_next = 1; step(); step(); rst_next = 0;
        repeat (10) step();
        chk("rmid_no_rvalid", if_rv_cnt - base_if, 0);
        chk("rmid_busy", busy, 0);
        chk("rmid_err", err_spurious, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Arbitrates one shared single-ported instruction/data memory between the fetch stage (IF, read-only) and the load/store unit (LSU, read/write).
- Sits between the IF/MEM pipeline stages and the unified memory model.
- Holds at most one outstanding transaction.
- Gives LSU priority, with a starvation guard for IF.

Parameters:
ADDR_W, 32, address width of all address ports
MAX_LSU_STREAK, 4, max consecutive contested LSU grants before IF is forced to win (range 1..15)

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
if_req  in  1  fetch read request; held until if_gnt
if_addr  in  ADDR_W  fetch address
if_gnt  out  1  one-cycle pulse: IF request latched
if_rvalid  out  1  one-cycle pulse: if_rdata valid
if_rdata  out  32  fetched instruction word
lsu_req  in  1  LSU request; held until lsu_gnt
lsu_we  in  1  1 = store, 0 = load
lsu_addr  in  ADDR_W  LSU address
lsu_wdata  in  32  store data
lsu_be  in  4  store byte enables
lsu_gnt  out  1  one-cycle pulse: LSU request latched
lsu_rvalid  out  1  one-cycle pulse: load data valid / store complete
lsu_rdata  out  32  load data; 0 for stores
mem_req  out  1  request to memory; held until mem_ready
mem_we  out  1  write enable to memory
mem_addr  out  ADDR_W  memory address
mem_wdata  out  32  memory write data
mem_be  out  4  memory byte enables; 4'hF for IF reads
mem_ready  in  1  memory accepts request this cycle
mem_rvalid  in  1  memory response (read data or write ack), one cycle
mem_rdata  in  32  memory read data
busy  out  1  1 in any state other than IDLE
err_spurious  out  1  sticky: mem_rvalid seen outside WAIT_RESP

Behaviour:
- Reset: all outputs 0; state IDLE; owner = IF; streak counter = 0; err_spurious cleared. Reset mid-transaction drops the in-flight response; no rvalid is issued.
- All outputs are registered.
- FSM states: IDLE, ISSUE, WAIT_RESP.
- IDLE, no request: stay in IDLE.
- IDLE, request present:
  - Choose the winner.
  - Latch addr/we/wdata/be (IF: we = 0, be = 4'hF, wdata = 0) into mem_* registers.
  - Record owner; pulse the winner's gnt next cycle; move to ISSUE with mem_req = 1.
  - The requester may change its inputs from the cycle after gnt.
- ISSUE: mem_req and payload held stable. On mem_req && mem_ready: next cycle mem_req = 0, state = WAIT_RESP. mem_ready while mem_req = 0 is ignored.
- WAIT_RESP, on mem_rvalid:
  - Next cycle the owner's rvalid pulses and its rdata = mem_rdata (LSU store: rdata = 0).
  - State returns to IDLE on the same edge.
  - Non-owner rvalid/rdata stay 0.
- Best-case timing: req seen in cycle N → gnt and mem_req in N+1 → mem_ready in N+1 → mem_rvalid in N+2 → rvalid in N+3. Next arbitration in N+3; next gnt in N+4.
- Arbitration when only one requester is active: that requester wins.
- Arbitration when both are active:
  - LSU wins unless streak == MAX_LSU_STREAK, in which case IF wins.
  - Streak counter: +1 on each LSU grant made while if_req = 1 (saturates at MAX_LSU_STREAK).
  - Streak counter clears on any IF grant, and on any cycle in IDLE with if_req = 0.
- mem_rvalid in IDLE or ISSUE: ignored for data, sets err_spurious.
- mem_rvalid and mem_ready together in ISSUE: ready is honoured, rvalid is treated as spurious.
- Requests arriving while busy are not granted. They are evaluated at the next IDLE cycle.

Optional Feature:
- Macro ARB_ROUND_ROBIN_EN.
- Defined:
  - Streak counter and MAX_LSU_STREAK are unused.
  - When both request, the requester that did NOT win the previous grant wins (last winner resets to IF, so LSU wins the first contested grant).
  - Single requester always wins.
- Undefined: LSU priority with the streak guard, as above.

Test Plan:
- Reset then single IF read: if_req = 1, if_addr = 32'h0000_0010; memory with mem_ready = 1 and 1-cycle rvalid returning 32'h0040_0093.
  → if_gnt at N+1, mem_addr = 32'h10, mem_be = 4'hF, mem_we = 0; if_rvalid at N+3 with if_rdata = 32'h0040_0093; lsu_rvalid stays 0.
- LSU store with backpressure: lsu_we = 1, lsu_addr = 32'h100, lsu_wdata = 32'hDEAD_BEEF, lsu_be = 4'b0011; mem_ready low for 3 cycles.
  → mem_req held 4 cycles with a stable payload; lsu_rvalid pulses once with lsu_rdata = 0.
- Simultaneous requests, both held continuously (default build, MAX_LSU_STREAK = 4).
  → grant order: LSU, LSU, LSU, LSU, IF, LSU…
- Same stimulus with ARB_ROUND_ROBIN_EN.
  → grant order: LSU, IF, LSU, IF.
- Spurious response: mem_rvalid = 1 while IDLE.
  → err_spurious = 1 and stays 1 until rst; no rvalid output.
- Reset mid-transaction: assert rst in WAIT_RESP, then mem_rvalid arrives after rst deasserts.
  → no rvalid output; busy = 0; err_spurious = 1.
